// File: rtl/tff_pkg.sv
// ---------------------------------------------------------------------------
// tff_pkg
// Shared definitions for the T-flip-flop counter bank.
//   mode_t      : 2-bit operating mode of the bank
//   MODE_TOGGLE : per-bit toggle mask (T input)
//   MODE_UP     : synchronous binary up counter
//   MODE_DOWN   : synchronous binary down counter
//   MODE_LOAD   : parallel load from D
// ---------------------------------------------------------------------------
package tff_pkg;

    typedef enum logic [1:0] {
        MODE_TOGGLE = 2'b00,
        MODE_UP     = 2'b01,
        MODE_DOWN   = 2'b10,
        MODE_LOAD   = 2'b11
    } mode_t;

endpackage : tff_pkg

// File: rtl/tff_cell.sv
// ---------------------------------------------------------------------------
// tff_cell
// One T-type flip-flop with an asynchronous, active-high reset to a
// per-instance reset value.
// Ports:
//   CLK     : rising-edge clock
//   RST     : asynchronous active-high reset
//   RST_VAL : value taken by Q while RST is high
//   T       : toggle request; Q inverts on the edge when high
//   Q       : registered state
// ---------------------------------------------------------------------------
module tff_cell (
    input  logic CLK,
    input  logic RST,
    input  logic RST_VAL,
    input  logic T,
    output logic Q
);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            Q <= RST_VAL;
        end else begin
            Q <= Q ^ T;
        end
    end

endmodule : tff_cell

// File: rtl/tff_counter_bank.sv
// ---------------------------------------------------------------------------
// tff_counter_bank
// Bank of WIDTH T flip-flops driven by a shared toggle-generation network.
// Depending on MODE the bank behaves as a masked toggle register, an up
// counter, a down counter or a loadable register.
// Parameters:
//   WIDTH     : number of bits in Q (1..32)
//   RESET_VAL : value of Q during reset
//   WRAP      : 1 = wrap at the count boundary, 0 = saturate there
// Ports:
//   CLK  : rising-edge clock
//   RST  : asynchronous active-high reset
//   EN   : synchronous enable; when low Q holds and OVF clears
//   MODE : 00 toggle, 01 up, 10 down, 11 load
//   T    : per-bit toggle request (toggle mode)
//   D    : parallel load data (load mode)
//   Q    : registered state
//   TC   : combinational terminal count (ignores EN)
//   OVF  : registered one-cycle overflow/underflow pulse
// ---------------------------------------------------------------------------
module tff_counter_bank
    import tff_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter bit               WRAP      = 1'b1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic [1:0]       MODE,
    input  logic [WIDTH-1:0] T,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             TC,
    output logic             OVF
);

    mode_t            w_mode;
    logic [WIDTH-1:0] w_upTog;
    logic [WIDTH-1:0] w_downTog;
    logic [WIDTH-1:0] w_tog;
    logic             w_allOnes;
    logic             w_allZero;
    logic             w_boundary;
    logic             r_ovf;

    assign w_mode = mode_t'(MODE);

    // Classic synchronous-counter toggle chains: a bit flips when every
    // lower bit is 1 (counting up) or every lower bit is 0 (counting down).
    assign w_upTog[0]   = 1'b1;
    assign w_downTog[0] = 1'b1;

    for (genvar i = 1; i < WIDTH; i++) begin : g_chain
        assign w_upTog[i]   = &Q[i-1:0];
        assign w_downTog[i] = ~|Q[i-1:0];
    end

    assign w_allOnes = &Q;
    assign w_allZero = ~|Q;

    assign TC = ((w_mode == MODE_UP)   && w_allOnes) ||
                ((w_mode == MODE_DOWN) && w_allZero);

    // An enabled edge taken at the boundary is the overflow/underflow event.
    assign w_boundary = EN && TC;

    // Toggle vector selection. In saturating builds the boundary edge
    // suppresses every toggle so Q parks at all-ones or zero.
    always_comb begin
        w_tog = '0;
        if (EN) begin
            case (w_mode)
                MODE_TOGGLE: w_tog = T;
                MODE_UP:     w_tog = w_upTog;
                MODE_DOWN:   w_tog = w_downTog;
                MODE_LOAD:   w_tog = Q ^ D;
                default:     w_tog = '0;
            endcase
        end
        if (w_boundary && !WRAP) begin
            w_tog = '0;
        end
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_cell
        tff_cell u_cell (
            .CLK     (CLK),
            .RST     (RST),
            .RST_VAL (RESET_VAL[g]),
            .T       (w_tog[g]),
            .Q       (Q[g])
        );
    end

    // OVF reports the boundary event of the previous edge; it stays high
    // while a saturated counter keeps being enabled at the boundary.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_ovf <= 1'b0;
        end else begin
            r_ovf <= w_boundary;
        end
    end

    assign OVF = r_ovf;

endmodule : tff_counter_bank

// File: tb/tb_tff_counter_bank.sv
// ---------------------------------------------------------------------------
// tb_tff_counter_bank
// Drives three bank instances from shared stimulus: an 8-bit wrapping bank,
// an 8-bit saturating bank and a 1-bit wrapping bank. A behavioural model
// predicts each edge; predictions are queued when stimulus is applied and
// popped and compared once the edge has happened.
// ---------------------------------------------------------------------------
module tb_tff_counter_bank;

    logic       clk  = 1'b0;
    logic       rst  = 1'b0;
    logic       en   = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [7:0] t    = 8'h00;
    logic [7:0] d    = 8'h00;

    logic [7:0] qW, qS;
    logic       tcW, ovfW, tcS, ovfS;
    logic [0:0] q1;
    logic       tc1, ovf1;

    int nTests = 0;
    int nFails = 0;

    typedef struct packed {
        logic [7:0] qW;
        logic       tcW;
        logic       ovfW;
        logic [7:0] qS;
        logic       tcS;
        logic       ovfS;
        logic       q1;
        logic       tc1;
        logic       ovf1;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] mW, mS, m1;

    always #5 clk = ~clk;

    tff_counter_bank #(.WIDTH(8), .RESET_VAL(8'h5A), .WRAP(1'b1)) dutW (
        .CLK(clk), .RST(rst), .EN(en), .MODE(mode), .T(t), .D(d),
        .Q(qW), .TC(tcW), .OVF(ovfW)
    );

    tff_counter_bank #(.WIDTH(8), .RESET_VAL(8'h5A), .WRAP(1'b0)) dutS (
        .CLK(clk), .RST(rst), .EN(en), .MODE(mode), .T(t), .D(d),
        .Q(qS), .TC(tcS), .OVF(ovfS)
    );

    tff_counter_bank #(.WIDTH(1), .RESET_VAL(1'b0), .WRAP(1'b1)) dut1 (
        .CLK(clk), .RST(rst), .EN(en), .MODE(mode), .T(t[0:0]), .D(d[0:0]),
        .Q(q1), .TC(tc1), .OVF(ovf1)
    );

    // Arithmetic model of one edge: returns {ovf, nextQ}.
    function automatic logic [8:0] step(input logic [7:0] q, input logic [7:0] mask,
                                        input bit wrap, input logic en_,
                                        input logic [1:0] mode_, input logic [7:0] t_,
                                        input logic [7:0] d_);
        logic [7:0] nq;
        logic       bnd;
        bnd = en_ && (((mode_ == 2'd1) && (q == mask)) || ((mode_ == 2'd2) && (q == 8'h00)));
        if (!en_) begin
            nq = q;
        end else begin
            case (mode_)
                2'd0:    nq = q ^ (t_ & mask);
                2'd1:    nq = (q + 8'd1) & mask;
                2'd2:    nq = (q - 8'd1) & mask;
                default: nq = d_ & mask;
            endcase
        end
        if (bnd && !wrap) nq = q;
        return {bnd, nq};
    endfunction

    function automatic logic tcOf(input logic [7:0] q, input logic [7:0] mask,
                                  input logic [1:0] mode_);
        return ((mode_ == 2'd1) && (q == mask)) || ((mode_ == 2'd2) && (q == 8'h00));
    endfunction

    task automatic resetModel();
        mW = 8'h5A;
        mS = 8'h5A;
        m1 = 8'h00;
        sb.delete();
    endtask

    // Applies one cycle of stimulus, queues the prediction, waits past the edge.
    task automatic applyStimulus(input logic en_, input logic [1:0] mode_,
                                 input logic [7:0] t_, input logic [7:0] d_);
        logic [8:0] rW, rS, r1;
        exp_t       e;
        en   = en_;
        mode = mode_;
        t    = t_;
        d    = d_;
        rW = step(mW, 8'hFF, 1'b1, en_, mode_, t_, d_);
        rS = step(mS, 8'hFF, 1'b0, en_, mode_, t_, d_);
        r1 = step(m1, 8'h01, 1'b1, en_, mode_, t_, d_);
        mW = rW[7:0];
        mS = rS[7:0];
        m1 = r1[7:0];
        e.qW   = mW;    e.ovfW = rW[8]; e.tcW = tcOf(mW, 8'hFF, mode_);
        e.qS   = mS;    e.ovfS = rS[8]; e.tcS = tcOf(mS, 8'hFF, mode_);
        e.q1   = m1[0]; e.ovf1 = r1[8]; e.tc1 = tcOf(m1, 8'h01, mode_);
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        #1;
        nTests++;
        if ({qW, ovfW, qS, ovfS, q1, ovf1} !== {8'h5A, 1'b0, 8'h5A, 1'b0, 1'b0, 1'b0}) begin
            nFails++;
            $display("[TB] FAIL reset_async: got W=%h/%b S=%h/%b 1b=%b/%b, expected 5a/0 5a/0 0/0",
                     qW, ovfW, qS, ovfS, q1, ovf1);
        end
        @(posedge clk);
        #1;
        nTests++;
        if ({qW, ovfW} !== {8'h5A, 1'b0}) begin
            nFails++;
            $display("[TB] FAIL reset_hold: got q=%h ovf=%b, expected q=5a ovf=0", qW, ovfW);
        end
        #2 rst = 1'b0;
        resetModel();
        for (int i = 0; i < 3; i++) begin
            exp_t e;
            applyStimulus(1'b0, 2'd1, 8'h00, 8'h00);
            e = sb.pop_front();
            nTests++;
            if ({qW, ovfW} !== {e.qW, e.ovfW}) begin
                nFails++;
                $display("[TB] FAIL reset_en0 edge %0d: got q=%h ovf=%b, expected q=%h ovf=%b",
                         i, qW, ovfW, e.qW, e.ovfW);
            end
        end
    endtask

    task automatic test_up_wrap();
        exp_t e;
        applyStimulus(1'b1, 2'd3, 8'h00, 8'hFD);
        e = sb.pop_front();
        nTests++;
        if (qW !== e.qW) begin
            nFails++;
            $display("[TB] FAIL up_load: got q=%h, expected q=%h", qW, e.qW);
        end
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 2'd1, 8'h00, 8'h00);
            e = sb.pop_front();
            nTests++;
            if ({qW, tcW, ovfW} !== {e.qW, e.tcW, e.ovfW}) begin
                nFails++;
                $display("[TB] FAIL up_wrap edge %0d: got q=%h tc=%b ovf=%b, expected q=%h tc=%b ovf=%b",
                         i, qW, tcW, ovfW, e.qW, e.tcW, e.ovfW);
            end
            nTests++;
            if ({qS, tcS, ovfS} !== {e.qS, e.tcS, e.ovfS}) begin
                nFails++;
                $display("[TB] FAIL up_sat edge %0d: got q=%h tc=%b ovf=%b, expected q=%h tc=%b ovf=%b",
                         i, qS, tcS, ovfS, e.qS, e.tcS, e.ovfS);
            end
        end
    endtask

    task automatic test_down_saturate();
        exp_t e;
        applyStimulus(1'b1, 2'd3, 8'h00, 8'h02);
        e = sb.pop_front();
        nTests++;
        if (qS !== e.qS) begin
            nFails++;
            $display("[TB] FAIL down_load: got q=%h, expected q=%h", qS, e.qS);
        end
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 2'd2, 8'h00, 8'h00);
            e = sb.pop_front();
            nTests++;
            if ({qS, tcS, ovfS} !== {e.qS, e.tcS, e.ovfS}) begin
                nFails++;
                $display("[TB] FAIL down_sat edge %0d: got q=%h tc=%b ovf=%b, expected q=%h tc=%b ovf=%b",
                         i, qS, tcS, ovfS, e.qS, e.tcS, e.ovfS);
            end
            nTests++;
            if ({qW, tcW, ovfW} !== {e.qW, e.tcW, e.ovfW}) begin
                nFails++;
                $display("[TB] FAIL down_wrap edge %0d: got q=%h tc=%b ovf=%b, expected q=%h tc=%b ovf=%b",
                         i, qW, tcW, ovfW, e.qW, e.tcW, e.ovfW);
            end
        end
        // Saturated bank has OVF high here; an async reset must clear it at once.
        #2 rst = 1'b1;
        #1;
        nTests++;
        if ({qS, ovfS} !== {8'h5A, 1'b0}) begin
            nFails++;
            $display("[TB] FAIL sat_reset: got q=%h ovf=%b, expected q=5a ovf=0", qS, ovfS);
        end
        #2 rst = 1'b0;
        resetModel();
    endtask

    task automatic test_toggle_mask();
        exp_t       e;
        logic [7:0] masks [3];
        masks[0] = 8'hF0;
        masks[1] = 8'h00;
        masks[2] = 8'hA5;
        applyStimulus(1'b1, 2'd3, 8'h00, 8'h0F);
        void'(sb.pop_front());
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 2'd0, masks[i], 8'h00);
            e = sb.pop_front();
            nTests++;
            if ({qW, tcW, ovfW, qS, ovfS} !== {e.qW, e.tcW, e.ovfW, e.qS, e.ovfS}) begin
                nFails++;
                $display("[TB] FAIL toggle T=%h: got W=%h tc=%b ovf=%b S=%h ovf=%b, expected W=%h tc=%b ovf=%b S=%h ovf=%b",
                         masks[i], qW, tcW, ovfW, qS, ovfS, e.qW, e.tcW, e.ovfW, e.qS, e.ovfS);
            end
        end
    endtask

    task automatic test_reset_mid_count();
        exp_t e;
        applyStimulus(1'b1, 2'd3, 8'h00, 8'h10);
        void'(sb.pop_front());
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 2'd1, 8'h00, 8'h00);
            e = sb.pop_front();
            nTests++;
            if (qW !== e.qW) begin
                nFails++;
                $display("[TB] FAIL midcount edge %0d: got q=%h, expected q=%h", i, qW, e.qW);
            end
        end
        #2 rst = 1'b1;
        #1;
        nTests++;
        if ({qW, ovfW} !== {8'h5A, 1'b0}) begin
            nFails++;
            $display("[TB] FAIL midcount_reset: got q=%h ovf=%b, expected q=5a ovf=0", qW, ovfW);
        end
        #2 rst = 1'b0;
        resetModel();
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, 2'd1, 8'h00, 8'h00);
            e = sb.pop_front();
            nTests++;
            if (qW !== e.qW) begin
                nFails++;
                $display("[TB] FAIL restart edge %0d: got q=%h, expected q=%h", i, qW, e.qW);
            end
        end
    endtask

    task automatic test_enable_boundary();
        exp_t       e;
        logic       ens [4];
        ens[0] = 1'b0;
        ens[1] = 1'b0;
        ens[2] = 1'b1;
        ens[3] = 1'b1;
        applyStimulus(1'b1, 2'd3, 8'h00, 8'hFF);
        void'(sb.pop_front());
        for (int i = 0; i < 4; i++) begin
            applyStimulus(ens[i], 2'd1, 8'h00, 8'h00);
            e = sb.pop_front();
            nTests++;
            if ({qW, tcW, ovfW} !== {e.qW, e.tcW, e.ovfW}) begin
                nFails++;
                $display("[TB] FAIL en_boundary edge %0d: got q=%h tc=%b ovf=%b, expected q=%h tc=%b ovf=%b",
                         i, qW, tcW, ovfW, e.qW, e.tcW, e.ovfW);
            end
        end
    endtask

    task automatic test_width1();
        exp_t       e;
        logic [1:0] modes [5];
        modes[0] = 2'd3;
        modes[1] = 2'd1;
        modes[2] = 2'd1;
        modes[3] = 2'd2;
        modes[4] = 2'd2;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, modes[i], 8'h00, 8'h00);
            e = sb.pop_front();
            nTests++;
            if ({q1, tc1, ovf1} !== {e.q1, e.tc1, e.ovf1}) begin
                nFails++;
                $display("[TB] FAIL width1 edge %0d: got q=%b tc=%b ovf=%b, expected q=%b tc=%b ovf=%b",
                         i, q1, tc1, ovf1, e.q1, e.tc1, e.ovf1);
            end
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: time %0t reached, expected finish before 100000", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        resetModel();
        test_reset();
        test_up_wrap();
        test_down_saturate();
        test_toggle_mask();
        test_reset_mid_count();
        test_enable_boundary();
        test_width1();
        $display("[TB] %0d tests run, %0d failed", nTests, nFails);
        $finish;
    end

endmodule : tb_tff_counter_bank

// File: doc/tff_counter_bank.md
Name: tff_counter_bank

Overview:
- Parametrised bank of T-type flip-flops, one per bit, with a shared mode-controlled toggle-generation network.
- One instance serves as any of: a masked toggle register, a synchronous up counter, a synchronous down counter, or a loadable register.
- Successor to the single-bit, reset-less toggle flip-flop: adds width, async reset, enable, modes, saturation and overflow flag.
- Sits in the FlipFlops library as the building block for dividers, event counters and LED/strobe toggles.

Parameters:
- WIDTH, 8, number of bits in Q; legal range 1..32.
- RESET_VAL, 0, value loaded into Q on reset; WIDTH bits.
- WRAP, 1, counting at a boundary: 1 = wrap around; 0 = saturate at the boundary.

Ports:
- CLK  input  1  rising-edge clock.
- RST  input  1  asynchronous, active-high reset.
- EN  input  1  synchronous enable; when 0, Q holds and OVF is cleared.
- MODE  input  2  00 toggle-mask, 01 count up, 10 count down, 11 parallel load.
- T  input  WIDTH  per-bit toggle request; used in mode 00 only.
- D  input  WIDTH  parallel load data; used in mode 11 only.
- Q  output  WIDTH  registered state.
- TC  output  1  combinational terminal count.
- OVF  output  1  registered one-cycle overflow/underflow pulse.

Behaviour:
Reset
- RST high forces Q=RESET_VAL and OVF=0 immediately, independent of CLK.
- Q and OVF hold these values while RST is high.
- First update occurs on the first rising CLK edge after RST deasserts.
- Reset asserted mid-count aborts the count; there is no partial state.

Per-bit structure
- Each bit is a T cell: Q[i] <= Q[i] ^ tog[i] on posedge CLK.
- tog is computed combinationally from the current mode:
  - EN=0: tog = 0.
  - Mode 00: tog = T. Each bit with T[i]=1 inverts on the edge.
  - Mode 01 (up): tog[0]=1; tog[i] = AND of Q[i-1:0]. Result is Q+1 mod 2^WIDTH.
  - Mode 10 (down): tog[0]=1; tog[i] = AND of ~Q[i-1:0]. Result is Q-1 mod 2^WIDTH.
  - Mode 11 (load): tog = Q ^ D, so Q <= D.
- Latency is one cycle from input to Q in every mode.

Boundaries
- TC = 1 when MODE=01 and Q = all ones, or MODE=10 and Q = 0. Otherwise TC = 0. TC ignores EN.
- Boundary edge with EN=1 and TC=1:
  - WRAP=1: Q wraps (all ones -> 0 going up; 0 -> all ones going down). OVF <= 1 for exactly one cycle.
  - WRAP=0: tog is forced to 0 so Q holds at the boundary. OVF <= 1 on every such edge, i.e. OVF stays high while the block sits saturated with EN=1.
- All other edges: OVF <= 0.
- OVF is never set in modes 00 or 11.

Other rules
- A mode change takes effect on the next edge. No pipeline state is carried between modes.
- WIDTH=1: up and down modes both toggle every enabled edge; TC follows the rule above.
- No X propagation: all combinational paths are fully specified for every MODE value.

Decomposition:
- Shared package tff_pkg:
  - Mode constants MODE_TOGGLE=2'b00, MODE_UP=2'b01, MODE_DOWN=2'b10, MODE_LOAD=2'b11.
  - mode_t typedef (2-bit).
- Sub-module tff_cell: one bit. Ports CLK, RST, RST_VAL, T, Q. Async active-high reset to RST_VAL. Instantiated WIDTH times in a generate loop.
- Top level holds the toggle-generation logic, the TC/saturation logic and the OVF flop.

Test Plan:
1. Reset: WIDTH=8, RESET_VAL=8'h5A. Assert RST between clock edges -> Q=8'h5A with no CLK edge. Release RST, EN=0, 3 edges -> Q stays 8'h5A, OVF=0.
2. Up wrap: WRAP=1, load D=8'hFD (MODE=11), then MODE=01 with EN=1 for 4 edges -> Q=FE, FF, 00, 01. TC=1 only while Q=FF. OVF high only in the cycle Q=00.
3. Down saturate: WRAP=0, load 8'h02, MODE=10 for 4 edges -> Q=01, 00, 00, 00. OVF=1 in each cycle that follows an edge taken at 00 with EN=1.
4. Toggle mask: Q=8'h0F, MODE=00, T=8'hF0 -> Q=8'hFF after one edge. Repeat with T=8'h00 -> Q holds 8'hFF. OVF=0 throughout.
5. Reset mid-count: counting up from 8'h10, assert RST asynchronously after Q=8'h13 -> Q=RESET_VAL and OVF=0 immediately. Count restarts from RESET_VAL after release.
6. Enable gating at boundary: Q=8'hFF, MODE=01, EN=0 for 2 edges -> Q=FF, TC=1, OVF=0. Then set EN=1 -> next edge gives Q=00 (WRAP=1) and OVF=1 for one cycle.
